fetch_stage: RTL and testbench

Instruction-fetch stage of the 5-stage MIPS pipeline. It sits directly upstream of instruction decode. It owns the PC register and drives a variable-latency instruction-memory request/ready interface. It loads the IF/ID register (instruction_IF, PC_sumado_IF, valid_IF) consumed by decode. It also handles hazard stalls and branch/jump redirects resolved in the MEM stage, including discarding stale in-flight fetches.

---
 rtl/fetch_stage.sv | 136 +++++++++++++
 tb/tb_fetch_stage.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem port,
// loads IF/ID, and handles stalls plus MEM-stage branch/jump redirects.
module fetch_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_IF,
  input  logic        PCSrc,
  input  logic [31:0] PC_branch,
  input  logic        Jump,
  input  logic [31:0] PC_jump,
  output logic [31:0] instruction_IF,
  output logic [31:0] PC_sumado_IF,
  output logic        valid_IF,
  output logic [1:0]  state_dbg
);

  // Handshake: a fetch completes on an edge where imem_req and imem_ready are
  // both high; imem_req/imem_addr come from registered state only.
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_HOLD, S_DROP} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] skid_instr_q, skid_instr_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        redirect;
  logic [31:0] target;
  logic [31:0] pc_plus4;

  assign redirect = PCSrc | Jump;
  assign target   = PCSrc ? PC_branch : PC_jump;
  assign pc_plus4 = pc_q + 32'd4;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drop_addr_d  = drop_addr_q;
    skid_instr_d = skid_instr_q;
    skid_pc4_d   = skid_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
    case (state_q)
      S_IDLE: begin
        state_d = S_FETCH;
        if (redirect) pc_d = target;
      end
      S_FETCH: begin
        if (redirect) begin
          pc_d = target;
          // The outstanding request must still be retired before the target goes out.
          if (!imem_ready) begin
            drop_addr_d = pc_q;
            state_d     = S_DROP;
          end
        end else if (imem_ready) begin
          pc_d = pc_plus4;
          if (stall_IF) begin
            skid_instr_d = imem_rdata;
            skid_pc4_d   = pc_plus4;
            state_d      = S_HOLD;
          end else begin
            instr_d = imem_rdata;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
          end
        end else if (!stall_IF) begin
          instr_d = '0;
          valid_d = 1'b0;
        end
      end
      S_HOLD: begin
        if (redirect) begin
          pc_d    = target;
          state_d = S_FETCH;
        end else if (!stall_IF) begin
          instr_d = skid_instr_q;
          pc4_d   = skid_pc4_q;
          valid_d = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_DROP: begin
        if (redirect) pc_d = target;
        if (imem_ready) state_d = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
    // A redirect squashes IF/ID regardless of stall.
    if (redirect) begin
      instr_d = '0;
      pc4_d   = '0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      pc_q         <= PC_RESET;
      drop_addr_q  <= '0;
      skid_instr_q <= '0;
      skid_pc4_q   <= '0;
      instr_q      <= '0;
      pc4_q        <= '0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_addr_q  <= drop_addr_d;
      skid_instr_q <= skid_instr_d;
      skid_pc4_q   <= skid_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req       = (state_q == S_FETCH) || (state_q == S_DROP);
  assign imem_addr      = (state_q == S_DROP) ? drop_addr_q : pc_q;
  assign instruction_IF = instr_q;
  assign PC_sumado_IF   = pc4_q;
  assign valid_IF       = valid_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: random-latency memory, random stalls/redirects, and an
// in-order program-stream reference model checked whenever decode consumes IF/ID.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall_IF = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] PC_branch = '0;
  logic        Jump = 1'b0;
  logic [31:0] PC_jump = '0;
  logic [31:0] instruction_IF;
  logic [31:0] PC_sumado_IF;
  logic        valid_IF;
  logic [1:0]  state_dbg;

  fetch_stage #(.PC_RESET(32'h0000_0000)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .stall_IF       (stall_IF),
    .PCSrc          (PCSrc),
    .PC_branch      (PC_branch),
    .Jump           (Jump),
    .PC_jump        (PC_jump),
    .instruction_IF (instruction_IF),
    .PC_sumado_IF   (PC_sumado_IF),
    .valid_IF       (valid_IF),
    .state_dbg      (state_dbg)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int delivered = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hA000_0000;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  function automatic logic [31:0] rand_target();
    if ($urandom_range(0, 7) == 0) return 32'hFFFF_FFFC;
    return $urandom & 32'hFFFF_FFFC;
  endfunction

  // ---------------- memory driver ----------------
  int max_lat = 0;
  int lat = 0;
  int cnt = 0;
  bit new_txn = 1'b1;

  always @(posedge clk) begin
    #1;
    if (!rst_n || !imem_req) begin
      imem_ready = 1'b0;
      imem_rdata = $urandom;
      new_txn    = 1'b1;
    end else begin
      if (new_txn) begin
        lat     = $urandom_range(0, max_lat);
        cnt     = 0;
        new_txn = 1'b0;
      end
      imem_ready = (cnt == lat);
      imem_rdata = imem_ready ? mem_word(imem_addr) : $urandom;
      cnt++;
      if (imem_ready) new_txn = 1'b1;
    end
  end

  // ---------------- scoreboard / monitor ----------------
  // The reference is the program stream: sequential words from the last
  // redirect target (or reset PC), each consumed once when decode takes IF/ID.
  logic [63:0] exp_q[$];
  logic [31:0] model_pc = 32'h0;
  logic [63:0] exp_e;
  bit          flush_chk = 1'b0;
  bit          prev_pending = 1'b0;
  logic [31:0] prev_addr = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      model_pc = 32'h0;
      exp_q.delete();
      flush_chk    = 1'b0;
      prev_pending = 1'b0;
    end else begin
      if (flush_chk) begin
        check("flush_valid", {63'd0, valid_IF}, 64'd0);
        check("flush_ifid", {instruction_IF, PC_sumado_IF}, 64'd0);
      end
      if (!valid_IF) check("nop_when_invalid", {32'd0, instruction_IF}, 64'd0);
      if (prev_pending) begin
        check("req_held", {63'd0, imem_req}, 64'd1);
        check("addr_stable", {32'd0, imem_addr}, {32'd0, prev_addr});
      end
      if (valid_IF && !stall_IF) begin
        if (exp_q.size() == 0) begin
          exp_q.push_back({mem_word(model_pc), model_pc + 32'd4});
          model_pc = model_pc + 32'd4;
        end
        exp_e = exp_q.pop_front();
        check("ifid_stream", {instruction_IF, PC_sumado_IF}, exp_e);
        delivered++;
      end
      if (PCSrc || Jump) begin
        exp_q.delete();
        model_pc  = PCSrc ? PC_branch : PC_jump;
        flush_chk = 1'b1;
      end else begin
        flush_chk = 1'b0;
      end
      prev_pending = imem_req && !imem_ready;
      prev_addr    = imem_addr;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {63'd0, imem_req}, 64'd0);
    check({tag, "_addr"}, {32'd0, imem_addr}, 64'd0);
    check({tag, "_instr"}, {32'd0, instruction_IF}, 64'd0);
    check({tag, "_pc4"}, {32'd0, PC_sumado_IF}, 64'd0);
    check({tag, "_valid"}, {63'd0, valid_IF}, 64'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Zero-wait memory: back-to-back fetches.
    @(posedge clk); #1;
    check("first_req", {63'd0, imem_req}, 64'd1);
    check("first_addr", {32'd0, imem_addr}, 64'd0);
    @(posedge clk); #1;
    check("addr_4", {32'd0, imem_addr}, 64'd4);
    check("ifid_0", {31'd0, valid_IF, instruction_IF}, {31'd0, 1'b1, 32'hA000_0000});
    check("pc4_0", {32'd0, PC_sumado_IF}, 64'd4);
    @(posedge clk); #1;
    check("addr_8", {32'd0, imem_addr}, 64'd8);
    check("ifid_4", {instruction_IF, PC_sumado_IF}, {32'hA000_0004, 32'd8});

    // Stall while the word at 8 returns: skid holds it, no requests in HOLD.
    stall_IF = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      check("hold_no_req", {63'd0, imem_req}, 64'd0);
      check("hold_frozen", {instruction_IF, PC_sumado_IF}, {32'hA000_0004, 32'd8});
    end
    stall_IF = 1'b0;
    @(posedge clk); #1;
    check("unhold_ifid", {instruction_IF, PC_sumado_IF}, {32'hA000_0008, 32'd12});
    check("unhold_addr", {31'd0, imem_req, imem_addr}, {31'd0, 1'b1, 32'd12});

    // Random phase: variable latency, stalls, redirects, one async reset.
    max_lat = 3;
    for (int i = 0; i < 3000; i++) begin
      @(posedge clk); #1;
      if (i == 1500) begin
        #2 rst_n = 1'b0;
        PCSrc = 1'b0; Jump = 1'b0; stall_IF = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        continue;
      end
      stall_IF  = ($urandom_range(0, 99) < 25);
      PC_branch = rand_target();
      PC_jump   = rand_target();
      if ($urandom_range(0, 99) < 6) begin
        PCSrc = $urandom_range(0, 1) == 1;
        Jump  = PCSrc ? ($urandom_range(0, 1) == 1) : 1'b1;
      end else begin
        PCSrc = 1'b0;
        Jump  = 1'b0;
      end
    end

    // Drain with a clean pipe and make sure the stream kept moving.
    PCSrc = 1'b0; Jump = 1'b0; stall_IF = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    check("liveness", {63'd0, delivered >= 300}, 64'd1);

    $display("final dbg state %0d, delivered %0d", state_dbg, delivered);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
